// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core: one unified memory port, one shared ALU,
// an FSM-sequenced datapath, stall handshake, illegal-opcode trap and a
// registered retire strobe with its writeback value.
module riscv_multicycle #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [31:0] Result,
    output logic        retire,
    output logic        halted
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11,
        HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] pc_r;
    logic [31:0] oldpc_r;
    logic [31:0] instr_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] aluout_r;
    logic [31:0] data_r;
    logic [31:0] regs_r [0:31];
    logic        retire_r;
    logic [31:0] result_r;

    logic        mem_req_s;
    logic        mem_we_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic        wb_en_s;
    logic [31:0] wb_data_s;
    logic        retire_s;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;

    assign opcode_s = instr_r[6:0];
    assign funct3_s = instr_r[14:12];
    assign rd_s     = instr_r[11:7];

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic sub,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (f3)
            3'b000:  r = sub ? (x - y) : (x + y);
            3'b010:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b110:  r = x | y;
            3'b111:  r = x & y;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Opcode/funct legality check; anything unrecognised goes to ILLEGAL.
    function automatic state_t decode_next(input logic [31:0] ins);
        state_t n;
        case (ins[6:0])
            OP_LOAD, OP_STORE: n = (ins[14:12] == 3'b010) ? MEMADR : ILLEGAL;
            OP_REG: begin
                case (ins[14:12])
                    3'b000:                 n = ((ins[31:25] == 7'h00) || (ins[31:25] == 7'h20)) ? EXECR : ILLEGAL;
                    3'b010, 3'b110, 3'b111: n = (ins[31:25] == 7'h00) ? EXECR : ILLEGAL;
                    default:                n = ILLEGAL;
                endcase
            end
            OP_IMM: begin
                case (ins[14:12])
                    3'b000, 3'b010, 3'b110, 3'b111: n = EXECI;
                    default:                        n = ILLEGAL;
                endcase
            end
            OP_BR:   n = (ins[14:12] == 3'b000) ? BEQ : ILLEGAL;
            OP_JAL:  n = JAL;
            default: n = ILLEGAL;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] rf_read(input logic [31:0] rf [0:31], input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : rf[idx];
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, memory-port, writeback and retire decode.
    always_comb begin
        state_nx_s  = state_r;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = 32'd0;
        mem_wdata_s = 32'd0;
        wb_en_s     = 1'b0;
        wb_data_s   = 32'd0;
        retire_s    = 1'b0;
        case (state_r)
            FETCH: begin
                mem_req_s  = 1'b1;
                mem_addr_s = pc_r;
                if (mem_ready) begin
                    state_nx_s = DECODE;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            DECODE: state_nx_s = decode_next(instr_r);
            MEMADR: begin
                if (opcode_s == OP_LOAD) begin
                    state_nx_s = MEMREAD;
                end else begin
                    state_nx_s = MEMWRITE;
                end
            end
            MEMREAD: begin
                mem_req_s  = 1'b1;
                mem_addr_s = {aluout_r[31:2], 2'b00};
                if (mem_ready) begin
                    state_nx_s = MEMWB;
                end else begin
                    state_nx_s = MEMREAD;
                end
            end
            MEMWB: begin
                wb_en_s    = 1'b1;
                wb_data_s  = data_r;
                retire_s   = 1'b1;
                state_nx_s = FETCH;
            end
            MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = {aluout_r[31:2], 2'b00};
                mem_wdata_s = b_r;
                if (mem_ready) begin
                    retire_s   = 1'b1;
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = MEMWRITE;
                end
            end
            EXECR:  state_nx_s = ALUWB;
            EXECI:  state_nx_s = ALUWB;
            ALUWB: begin
                wb_en_s    = 1'b1;
                wb_data_s  = aluout_r;
                retire_s   = 1'b1;
                state_nx_s = FETCH;
            end
            BEQ: begin
                retire_s   = 1'b1;
                state_nx_s = FETCH;
            end
            JAL:    state_nx_s = ALUWB;
            ILLEGAL: begin
                if (ILLEGAL_HALT) begin
                    state_nx_s = HALT;
                end else begin
                    retire_s   = 1'b1;
                    state_nx_s = FETCH;
                end
            end
            HALT:    state_nx_s = HALT;
            default: state_nx_s = HALT;
        endcase
    end

    // Datapath registers: PC, IR, operand latches, ALU result and load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            oldpc_r  <= RESET_PC;
            instr_r  <= 32'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            aluout_r <= 32'd0;
            data_r   <= 32'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (mem_ready) begin
                        instr_r <= mem_rdata;
                        oldpc_r <= pc_r;
                        pc_r    <= pc_r + 32'd4;
                    end
                end
                DECODE: begin
                    a_r      <= rf_read(regs_r, instr_r[19:15]);
                    b_r      <= rf_read(regs_r, instr_r[24:20]);
                    aluout_r <= oldpc_r + imm_b(instr_r);
                end
                MEMADR:  aluout_r <= a_r + ((opcode_s == OP_STORE) ? imm_s(instr_r) : imm_i(instr_r));
                MEMREAD: begin
                    if (mem_ready) begin
                        data_r <= mem_rdata;
                    end
                end
                EXECR:   aluout_r <= alu_f(funct3_s, instr_r[30], a_r, b_r);
                EXECI:   aluout_r <= alu_f(funct3_s, 1'b0, a_r, imm_i(instr_r));
                BEQ: begin
                    if (a_r == b_r) begin
                        pc_r <= {aluout_r[31:2], 2'b00};
                    end
                end
                JAL: begin
                    pc_r     <= (oldpc_r + imm_j(instr_r)) & 32'hFFFF_FFFC;
                    aluout_r <= oldpc_r + 32'd4;
                end
                default: ;
            endcase
        end
    end

    // Register file; x0 is never written so it always reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wb_en_s && (rd_s != 5'd0)) begin
            regs_r[rd_s] <= wb_data_s;
        end
    end

    // Registered retire pulse and the value written by the retiring instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_r <= 1'b0;
            result_r <= 32'd0;
        end else begin
            retire_r <= retire_s;
            if (retire_s) begin
                result_r <= (wb_en_s && (rd_s != 5'd0)) ? wb_data_s : 32'd0;
            end
        end
    end

    // Reset gates the request path so an in-flight access is abandoned at once.
    assign mem_req   = mem_req_s & ~reset;
    assign mem_we    = mem_we_s & ~reset;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign PC        = pc_r;
    assign Instr     = instr_r;
    assign Result    = result_r;
    assign retire    = retire_r;
    assign halted    = (state_r == HALT);

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: program image + scoreboard of
// expected retirements (value, latency, PC, IR) with a wait-state memory.
module tb_riscv_multicycle;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [31:0] Result;
    logic        retire;
    logic        halted;

    riscv_multicycle #(.RESET_PC(32'h0000_0100), .ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .PC(PC), .Instr(Instr), .Result(Result),
        .retire(retire), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: image copied in on load_req, wait states chosen by address.
    logic [31:0] mem      [0:255];
    logic [31:0] init_mem [0:255];
    logic        load_req;
    logic        long_stall;
    int          wcnt;
    int          waits;

    always_comb begin
        waits = 0;
        if (long_stall && mem_addr == 32'h8) waits = 1000;
        else if (mem_addr == 32'h10C || mem_addr == 32'h110 || mem_addr == 32'h8) waits = 2;
        else waits = 0;
    end

    assign mem_ready = mem_req && (wcnt >= waits);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
            wcnt <= 0;
        end else if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            wcnt <= 0;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    typedef struct {
        logic [31:0] res;
        int          lat;
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_sw(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_lw(input int imm, input logic [4:0] rs1, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] enc_beq(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, 3'b000, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_jal(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word, input logic [31:0] res,
                       input int lat, input logic [31:0] pc_after);
        exp_t e;
        init_mem[addr[9:2]] = word;
        e.res = res; e.lat = lat; e.pc = pc_after; e.ins = word;
        q.push_back(e);
    endtask

    task automatic do_load();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   cyc;
        logic [31:0] held_addr;

        reset = 1'b1; load_req = 1'b0; long_stall = 1'b0;
        for (int i = 0; i < 256; i++) init_mem[i] = 32'h0;

        // Program in execution order: expected Result, cycles, PC after retire.
        put(32'h100, enc_i(5, 5'd0, 3'b000, 5'd1),            32'd5,          4, 32'h104);
        put(32'h104, enc_i(7, 5'd0, 3'b000, 5'd2),            32'd7,          4, 32'h108);
        put(32'h108, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),  32'd12,         4, 32'h10C);
        put(32'h10C, enc_sw(8, 5'd3, 5'd0),                   32'd0,          8, 32'h110);
        put(32'h110, enc_lw(8, 5'd0, 5'd4),                   32'd12,         9, 32'h114);
        put(32'h114, enc_beq(100, 5'd2, 5'd1),                32'd0,          3, 32'h118);
        put(32'h118, enc_jal(16, 5'd5),                       32'h11C,        4, 32'h128);
        put(32'h128, enc_beq(-8, 5'd1, 5'd1),                 32'd0,          3, 32'h120);
        put(32'h120, enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd6),  32'd2,          4, 32'h124);
        put(32'h124, enc_beq(12, 5'd0, 5'd0),                 32'd0,          3, 32'h130);
        put(32'h130, enc_i(-3, 5'd0, 3'b000, 5'd8),           32'hFFFF_FFFD,  4, 32'h134);
        put(32'h134, enc_i(0, 5'd8, 3'b010, 5'd9),            32'd1,          4, 32'h138);
        put(32'h138, enc_r(7'h00, 5'd8, 5'd1, 3'b010, 5'd10), 32'd0,          4, 32'h13C);
        put(32'h13C, enc_i(6, 5'd2, 3'b111, 5'd11),           32'd6,          4, 32'h140);
        put(32'h140, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd12), 32'd7,          4, 32'h144);
        put(32'h144, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd13), 32'd5,          4, 32'h148);
        put(32'h148, enc_r(7'h00, 5'd5, 5'd4, 3'b000, 5'd14), 32'h128,        4, 32'h14C);
        put(32'h14C, enc_i(9, 5'd0, 3'b000, 5'd0),            32'd0,          4, 32'h150);
        init_mem[32'h150 >> 2] = 32'h0000_007F;

        do_load();
        @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_pc", PC, 32'h100);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);

        // Scoreboard drain: one expected record per retire pulse.
        while (q.size() > 0) begin
            e = q.pop_front();
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (!retire && cyc < 40);
            chk("retire_seen", {31'd0, retire}, 32'd1);
            chk("latency", cyc, e.lat);
            chk("result", Result, e.res);
            chk("pc", PC, e.pc);
            chk("instr", Instr, e.ins);
            if (e.pc == 32'h110) chk("sw_mem", mem[2], 32'd12);
        end

        // Illegal opcode: no retire, halted rises, memory stays idle.
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            chk("no_retire_illegal", {31'd0, retire}, 32'd0);
        end while (!halted && cyc < 20);
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_cycles", cyc, 3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("halt_req", {31'd0, mem_req}, 32'd0);
            chk("halt_stay", {31'd0, halted}, 32'd1);
        end

        // Reset during a stalled store: request drops at once, nothing commits.
        reset = 1'b1;
        long_stall = 1'b1;
        init_mem[32'h100 >> 2] = enc_sw(8, 5'd0, 5'd0);
        init_mem[2] = 32'hDEAD_BEEF;
        do_load();
        #1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!mem_we && cyc < 20);
        chk("store_we", {31'd0, mem_we}, 32'd1);
        chk("store_cycles", cyc, 3);
        held_addr = mem_addr;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_addr", mem_addr, held_addr);
            chk("stall_wdata", mem_wdata, 32'd0);
            chk("stall_we", {31'd0, mem_we}, 32'd1);
        end
        chk("stall_addr8", held_addr, 32'h8);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_pc", PC, 32'h100);
        chk("abort_retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_mem", mem[2], 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
